// File: rtl/session_pkg.sv
// session_pkg: shared encodings for the telephony session transmit path.
//   CMD_*      : transport command codes driven on session_tx_arbiter.cmd
//   OP_*       : control-message opcodes carried in ctrl_data[7:0]
//   out_state_e: output-register state; values match the cmd encoding so
//                the state register drives cmd directly.
package session_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_CTRL  = 2'b01;
  localparam logic [1:0] CMD_AUDIO = 2'b10;

  localparam logic [7:0] OP_CALL   = 8'h01;
  localparam logic [7:0] OP_ANSWER = 8'h02;
  localparam logic [7:0] OP_HANGUP = 8'h05;

  typedef enum logic [1:0] {
    OST_IDLE  = CMD_IDLE,
    OST_CTRL  = CMD_CTRL,
    OST_AUDIO = CMD_AUDIO
  } out_state_e;

endpackage

// File: rtl/ctrl_fifo.sv
// ctrl_fifo: synchronous FIFO with registered pointers that wrap at DEPTH.
//   clk, reset   : clock, synchronous active-low reset
//   wr_en_i/wr_data_i : push (ignored when full)
//   rd_en_i      : pop (ignored when empty); rd_data_o shows the head word
//   full_o, empty_o, count_o : status derived from the registered count
module ctrl_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic                    wr, rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a write is refused when full
  // even if a read frees a slot on the same edge.
  assign wr = wr_en_i && !full_o;
  assign rd = rd_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr, rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/session_tx_arbiter.sv
// session_tx_arbiter: shares the transport transmit path between queued
// control words and the newest audio sample.
//   clk, reset            : clock, synchronous active-low reset
//   ctrl_valid/data/ready : control word input into the FIFO
//   audio_valid/data      : one-cycle strobe of a new sample
//   audio_enable          : session connected; low discards pending audio
//   transportBusy         : transport cannot take the offered word
//   cmd, dataOut          : registered word offered to the transport
//   ctrl_count            : FIFO occupancy
//   audio_drops           : saturating count of overwritten samples
//   arbBusy               : anything held or pending
module session_tx_arbiter
  import session_pkg::*;
#(
  parameter int CTRL_DEPTH     = 4,
  parameter int MAX_CTRL_BURST = 3,
  parameter int DROP_W         = 8,
  localparam int CNT_W         = $clog2(CTRL_DEPTH) + 1,
  localparam int BW            = $clog2(MAX_CTRL_BURST + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_valid,
  input  logic [15:0]       ctrl_data,
  output logic              ctrl_ready,
  input  logic              audio_valid,
  input  logic [15:0]       audio_data,
  input  logic              audio_enable,
  input  logic              transportBusy,
  output logic [1:0]        cmd,
  output logic [15:0]       dataOut,
  output logic [CNT_W-1:0]  ctrl_count,
  output logic [DROP_W-1:0] audio_drops,
  output logic              arbBusy
);

  out_state_e        st_q, st_d;
  logic [15:0]       data_q, data_d;
  logic              pend_q, pend_d;
  logic [15:0]       aud_q, aud_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [DROP_W-1:0] drops_q, drops_d;

  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_head;
  logic        accept, load, burst_cap, take_ctrl, take_audio;

  ctrl_fifo #(.DEPTH(CTRL_DEPTH), .W(16)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ctrl_valid),
    .wr_data_i (ctrl_data),
    .rd_en_i   (take_ctrl),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (ctrl_count)
  );

  assign accept     = (st_q != OST_IDLE) && !transportBusy;
  assign load       = (st_q == OST_IDLE) || accept;
  // Audio has waited through MAX_CTRL_BURST control grants: it goes next.
  assign burst_cap  = pend_q && (burst_q == BW'(MAX_CTRL_BURST));
  assign take_ctrl  = load && !fifo_empty && !burst_cap;
  assign take_audio = load && !take_ctrl && pend_q;

  always_comb begin
    st_d    = st_q;
    data_d  = data_q;
    burst_d = burst_q;
    pend_d  = pend_q;
    aud_d   = aud_q;
    drops_d = drops_q;

    // dataOut keeps its last value when going idle; only cmd marks validity.
    if (load) begin
      if (take_ctrl) begin
        st_d   = OST_CTRL;
        data_d = fifo_head;
      end else if (take_audio) begin
        st_d   = OST_AUDIO;
        data_d = aud_q;
      end else begin
        st_d   = OST_IDLE;
      end
    end

    if (!pend_q || take_audio)
      burst_d = '0;
    else if (take_ctrl && burst_q != BW'(MAX_CTRL_BURST))
      burst_d = burst_q + BW'(1);

    // Disable wins over a strobe; the output register is not touched, so a
    // held audio word still completes.
    if (!audio_enable) begin
      pend_d = 1'b0;
    end else if (audio_valid) begin
      pend_d = 1'b1;
      aud_d  = audio_data;
      if (pend_q && !take_audio && drops_q != '1)
        drops_d = drops_q + DROP_W'(1);
    end else if (take_audio) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q    <= OST_IDLE;
      data_q  <= '0;
      pend_q  <= 1'b0;
      aud_q   <= '0;
      burst_q <= '0;
      drops_q <= '0;
    end else begin
      st_q    <= st_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      aud_q   <= aud_d;
      burst_q <= burst_d;
      drops_q <= drops_d;
    end
  end

  assign cmd         = st_q;
  assign dataOut     = data_q;
  assign ctrl_ready  = !fifo_full;
  assign audio_drops = drops_q;
  assign arbBusy     = (st_q != OST_IDLE) || !fifo_empty || pend_q;

endmodule

// File: tb/tb_session_tx_arbiter.sv
module tb_session_tx_arbiter;
  localparam int DEPTH = 4;
  localparam int MAXB  = 3;
  localparam int DW    = 8;
  localparam int DMAX  = (1 << DW) - 1;

  logic clk = 0, reset = 0;
  logic ctrl_valid = 0, audio_valid = 0, audio_enable = 1, transportBusy = 0;
  logic [15:0] ctrl_data = 0, audio_data = 0;
  logic ctrl_ready, arbBusy;
  logic [1:0] cmd;
  logic [15:0] dataOut;
  logic [$clog2(DEPTH):0] ctrl_count;
  logic [DW-1:0] audio_drops;

  session_tx_arbiter #(.CTRL_DEPTH(DEPTH), .MAX_CTRL_BURST(MAXB), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset), .ctrl_valid(ctrl_valid), .ctrl_data(ctrl_data),
    .ctrl_ready(ctrl_ready), .audio_valid(audio_valid), .audio_data(audio_data),
    .audio_enable(audio_enable), .transportBusy(transportBusy), .cmd(cmd),
    .dataOut(dataOut), .ctrl_count(ctrl_count), .audio_drops(audio_drops),
    .arbBusy(arbBusy));

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of control words, one pending audio slot, the
  // word on offer, and the count of control grants audio has waited through.
  logic [15:0] m_q[$];
  int m_cmd, m_burst, m_drops;
  logic [15:0] m_data, m_aud;
  bit m_pend;
  logic [17:0] obs[$];   // words the DUT handed to the transport {cmd,data}

  task automatic model_step();
    bit ld, tc, ta, wr;
    if (!reset) begin
      m_q.delete(); m_cmd = 0; m_data = 0; m_pend = 0; m_aud = 0;
      m_burst = 0; m_drops = 0;
    end else begin
      ld = (m_cmd == 0) || !transportBusy;
      wr = ctrl_valid && (m_q.size() < DEPTH);
      tc = 0; ta = 0;
      if (ld) begin
        if (m_q.size() > 0 && !(m_pend && m_burst == MAXB)) begin
          tc = 1; m_cmd = 1; m_data = m_q.pop_front();
        end else if (m_pend) begin
          ta = 1; m_cmd = 2; m_data = m_aud;
        end else m_cmd = 0;
      end
      if (wr) m_q.push_back(ctrl_data);
      if (!m_pend || ta) m_burst = 0;
      else if (tc && m_burst < MAXB) m_burst++;
      if (!audio_enable) m_pend = 0;
      else if (audio_valid) begin
        if (m_pend && !ta && m_drops < DMAX) m_drops++;
        m_pend = 1; m_aud = audio_data;
      end else if (ta) m_pend = 0;
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising
  // edge, return 1 time unit later so the caller can drive the next inputs.
  task automatic cyc();
    @(negedge clk);
    chk("cmd", 32'(cmd), 32'(m_cmd));
    chk("dataOut", 32'(dataOut), 32'(m_data));
    chk("ctrl_ready", 32'(ctrl_ready), 32'(m_q.size() < DEPTH));
    chk("ctrl_count", 32'(ctrl_count), 32'(m_q.size()));
    chk("audio_drops", 32'(audio_drops), 32'(m_drops));
    chk("arbBusy", 32'(arbBusy), 32'(m_cmd != 0 || m_q.size() > 0 || m_pend));
    if (reset && cmd != 2'b00 && !transportBusy) obs.push_back({cmd, dataOut});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    ctrl_valid = 0; audio_valid = 0; audio_enable = 1; transportBusy = 0;
    reset = 0; cyc(); reset = 1;
  endtask

  task automatic wr_ctrl(input logic [15:0] d);
    ctrl_valid = 1; ctrl_data = d; cyc(); ctrl_valid = 0;
  endtask

  task automatic strobe(input logic [15:0] d);
    audio_valid = 1; audio_data = d; cyc(); audio_valid = 0;
  endtask

  task automatic chk_obs(input string tag, input int idx, input logic [1:0] c, input logic [15:0] d);
    if (idx < obs.size()) chk(tag, 32'(obs[idx]), 32'({c, d}));
    else chk({tag, "_missing"}, 32'(obs.size()), 32'(idx + 1));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    model_step();
    #1;
    // Reset state against constants
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_data", 32'(dataOut), 0);
    chk("rst_ready", 32'(ctrl_ready), 1);
    chk("rst_count", 32'(ctrl_count), 0);
    chk("rst_drops", 32'(audio_drops), 0);
    chk("rst_busy", 32'(arbBusy), 0);
    reset = 1;

    // Idle control: valid two edges after the write, gone one edge later
    wr_ctrl(16'h2A01);
    cyc();
    chk("idle_cmd", 32'(cmd), 1);
    chk("idle_data", 32'(dataOut), 32'h2A01);
    cyc();
    chk("idle_done", 32'(cmd), 0);

    // Busy hold on an audio word
    transportBusy = 1;
    strobe(16'h1234);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("hold_cmd", 32'(cmd), 2);
      chk("hold_data", 32'(dataOut), 32'h1234);
      cyc();
    end
    transportBusy = 0; obs.delete();
    cyc();
    chk("hold_acc_n", 32'(obs.size()), 1);
    chk_obs("hold_acc", 0, 2'b10, 16'h1234);
    chk("hold_idle", 32'(cmd), 0);

    // FIFO full and wrap: one word in the output register, four in the FIFO
    do_reset();
    transportBusy = 1;
    for (int i = 0; i < 5; i++) wr_ctrl(16'hC000 + 16'(i));
    chk("full_ready", 32'(ctrl_ready), 0);
    chk("full_count", 32'(ctrl_count), 4);
    wr_ctrl(16'hC0FF);
    chk("full_refused", 32'(ctrl_count), 4);
    transportBusy = 0; obs.delete();
    repeat (8) cyc();
    chk("full_n", 32'(obs.size()), 5);
    for (int i = 0; i < 5; i++) chk_obs("full_order", i, 2'b01, 16'hC000 + 16'(i));

    // Starvation guard: A0 held, then C,C,C,A,C
    do_reset();
    transportBusy = 1;
    strobe(16'hA000);
    for (int i = 1; i <= 4; i++) wr_ctrl(16'hB000 + 16'(i));
    strobe(16'hA001);
    transportBusy = 0; obs.delete();
    repeat (10) cyc();
    chk("starve_n", 32'(obs.size()), 6);
    chk_obs("starve0", 0, 2'b10, 16'hA000);
    chk_obs("starve1", 1, 2'b01, 16'hB001);
    chk_obs("starve2", 2, 2'b01, 16'hB002);
    chk_obs("starve3", 3, 2'b01, 16'hB003);
    chk_obs("starve4", 4, 2'b10, 16'hA001);
    chk_obs("starve5", 5, 2'b01, 16'hB004);

    // Overwrite: three strobes behind a held word, newest sample survives
    do_reset();
    transportBusy = 1;
    wr_ctrl(16'h3301);
    cyc();
    strobe(16'h5551); strobe(16'h5552); strobe(16'h5553);
    chk("ovw_drops", 32'(audio_drops), 2);
    transportBusy = 0; obs.delete();
    repeat (4) cyc();
    chk_obs("ovw_ctrl", 0, 2'b01, 16'h3301);
    chk_obs("ovw_last", 1, 2'b10, 16'h5553);

    // Disable: pending sample discarded, no extra drop
    transportBusy = 1;
    wr_ctrl(16'h3305);
    cyc();
    strobe(16'h6661); strobe(16'h6662);
    chk("dis_drops_pre", 32'(audio_drops), 3);
    audio_enable = 0;
    cyc();
    chk("dis_drops", 32'(audio_drops), 3);
    chk("dis_held", 32'(arbBusy), 1);
    audio_enable = 1; transportBusy = 0; obs.delete();
    repeat (4) cyc();
    chk("dis_n", 32'(obs.size()), 1);
    chk_obs("dis_ctrl", 0, 2'b01, 16'h3305);
    chk("dis_idle", 32'(arbBusy), 0);

    // Reset mid-transfer
    do_reset();
    transportBusy = 1;
    wr_ctrl(16'h0101); wr_ctrl(16'h0202); wr_ctrl(16'h0305);
    cyc();
    chk("mid_cmd", 32'(cmd), 1);
    chk("mid_count", 32'(ctrl_count), 2);
    reset = 0;
    cyc();
    chk("mid_rst_cmd", 32'(cmd), 0);
    chk("mid_rst_data", 32'(dataOut), 0);
    chk("mid_rst_ready", 32'(ctrl_ready), 1);
    chk("mid_rst_count", 32'(ctrl_count), 0);
    chk("mid_rst_busy", 32'(arbBusy), 0);
    reset = 1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ctrl_valid    = ($urandom_range(99) < 45);
      ctrl_data     = 16'($urandom);
      audio_valid   = ($urandom_range(99) < 30);
      audio_data    = 16'($urandom);
      audio_enable  = ($urandom_range(99) < 92);
      transportBusy = ($urandom_range(99) < 40);
      reset         = ($urandom_range(999) >= 8);
      cyc();
    end
    reset = 1; ctrl_valid = 0; audio_valid = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected finish before 2000000");
    $fatal(1);
  end
endmodule
